flow_row_scheduler: RTL and testbench
=====================================

// Module: flow_row_scheduler
// PURPOSE
//  Multiplexes FLUX independent pixel sources onto the single tagged write port of the
//  multi-flow interpolation datapath (din = {flow_id, pel}).
//  Each flow is configured with its extended block side (SIZE+TAP-1).
//  Flows are served round-robin with one full row per grant. Back-pressure comes from
//  the per-flow input FIFO full flags. A flow retires once all ext_size*ext_size pixels are sent.
// PARAMETERS
//  FLUX    4   number of flows (tag width TAG_W = $clog2(FLUX))
//  DATA_W  8   pixel width
//  SIZE_W  7   ext_size width; pixel total counter is 2*SIZE_W bits
// PORTS
//  clk        in   1                 clock
//  rst        in   1                 asynchronous reset, active-high
//  cfg_write  in   1                 configuration strobe
//  cfg_din    in   TAG_W+SIZE_W      {flow_id, ext_size}
//  cfg_err    out  1                 1-cycle pulse: cfg_write rejected
//  src_din    in   FLUX*DATA_W       per-flow pixel; flow f occupies bits [f*DATA_W +: DATA_W]
//  src_valid  in   FLUX              per-flow pixel available
//  src_ready  out  FLUX              per-flow pixel consumed this cycle
//  out_din    out  TAG_W+DATA_W      {flow_id, pel} to datapath write port
//  out_write  out  1                 write strobe to datapath
//  out_full   in   FLUX              per-flow datapath FIFO full
//  flow_done  out  FLUX              1-cycle pulse on the last pixel of a flow
//  busy       out  1                 any flow active
// BEHAVIOUR
//  Reset values: state=IDLE, rr_ptr=0, active=0, all counters 0.
//   All outputs are 0: out_write, out_din, src_ready, flow_done, cfg_err, busy.
//  Config: cfg_write with ext_size!=0 for a flow with active=0 has these effects:
//   - row_len[f] := ext_size; remaining[f] := ext_size*ext_size; active[f] := 1 (next edge).
//   Rejection cases, each giving a cfg_err pulse next cycle with no state change:
//   - flow already active;
//   - ext_size==0;
//   - the flow retires in the same cycle as the write.
//  FSM:
//   IDLE   -> SELECT when active!=0.
//   SELECT: eligible = active & src_valid & ~out_full. The first eligible flow after
//     rr_ptr in circular order wins (rr_ptr itself is checked last).
//     On a win: cur := flow, row_cnt := row_len[cur], go to STREAM.
//     No eligible flow: stay in SELECT. active==0: go to IDLE.
//     SELECT costs exactly 1 cycle per grant.
//   STREAM: xfer = src_valid[cur] & ~out_full[cur]. The datapath is combinational, 0 latency:
//     - out_write = xfer
//     - out_din = xfer ? {cur, src_din[cur]} : 0
//     - src_ready = xfer ? onehot(cur) : 0
//     Each xfer decrements row_cnt and remaining[cur]. A stall (no xfer) holds everything;
//     rows are atomic and no other flow is served mid-row.
//     On the xfer where row_cnt==1: rr_ptr := cur, go to SELECT.
//     If that xfer also has remaining==1: active[cur] := 0 and flow_done[cur] pulses in the
//     same cycle as the last out_write.
//  Only one flow's src_ready or out_write is ever high. The tag always equals the cur register.
//  A cfg_write to a different, inactive flow during STREAM is accepted without disturbing the
//   current row. The new flow becomes eligible at the next SELECT.
//  Reset mid-row: asserting rst drops out_write/src_ready immediately (async).
//   All configuration is lost; the partial row is not resumed.
//  busy = |active (registered).
// TESTING
//  Single flow: cfg {0,15}, src always valid, no full.
//   -> 225 writes, tag 0, data in order; flow_done[0] on the 225th; 1 idle SELECT cycle
//      between rows (15 rows).
//  Four flows: ext 15/23/39/71, all valid.
//   -> tag order 0,1,2,3,0,... in rows of 15/23/39/71.
//   -> Flow 0 retires after 15 rows, then order 1,2,3.
//   -> Per-flow output counts 225/529/1521/5041.
//  Back-pressure: out_full[1] high for 10 cycles mid-row of flow 1.
//   -> out_write=0 and src_ready=0 for those cycles; the row resumes with no lost or
//      duplicated pixel and no switch to another flow.
//  Ineligible skip: flow 2 src_valid=0 at SELECT.
//   -> grant goes 1 -> 3. Flow 2 is served once valid; the round-robin order is preserved.
//  Config errors: cfg {1,23} while flow 1 is active -> cfg_err pulse, row_len unchanged.
//   cfg {2,0} -> cfg_err pulse. A cfg to flow 0 coincident with its last pixel -> cfg_err pulse.
//  Reset: rst asserted mid-row of flow 3 for 2 cycles.
//   -> all outputs 0 within the same cycle; busy=0; a new cfg then restarts cleanly from row 0.

Source files
------------

// File: rtl/flow_row_scheduler.sv
// flow_row_scheduler: round-robin, row-granular multiplexer of FLUX pixel
// sources onto one tagged datapath write port ({flow_id, pel}).
// A grant covers one full row of the flow's extended block. The row is held
// until it completes, and a flow retires after ext_size*ext_size pixels.
module flow_row_scheduler #(
    parameter int FLUX   = 4,
    parameter int DATA_W = 8,
    parameter int SIZE_W = 7,
    localparam int TAG_W = (FLUX > 1) ? $clog2(FLUX) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_write,
    input  logic [TAG_W+SIZE_W-1:0]   cfg_din,
    output logic                      cfg_err,
    input  logic [FLUX*DATA_W-1:0]    src_din,
    input  logic [FLUX-1:0]           src_valid,
    output logic [FLUX-1:0]           src_ready,
    output logic [TAG_W+DATA_W-1:0]   out_din,
    output logic                      out_write,
    input  logic [FLUX-1:0]           out_full,
    output logic [FLUX-1:0]           flow_done,
    output logic                      busy
);

    localparam int CNT_W = 2 * SIZE_W;

    typedef enum logic [1:0] {IDLE, SELECT, STREAM} state_t;

    state_t                 state_q, state_d;
    logic [TAG_W-1:0]       rr_ptr_q;
    logic [TAG_W-1:0]       cur_q;
    logic [SIZE_W-1:0]      row_cnt_q;
    logic [FLUX-1:0]        active_q;
    logic                   cfg_err_q;
    logic [SIZE_W-1:0]      row_len_q   [FLUX];
    logic [CNT_W-1:0]       remaining_q [FLUX];

    logic [TAG_W-1:0]       cfg_flow;
    logic [SIZE_W-1:0]      cfg_size;
    logic [CNT_W-1:0]       cfg_size_w;
    logic                   cfg_ok;
    logic [FLUX-1:0]        eligible;
    logic                   grant_found;
    logic [TAG_W-1:0]       grant_idx;
    logic                   xfer;
    logic                   row_end;
    logic                   last_px;
    logic [FLUX-1:0]        cur_onehot;

    assign cfg_flow   = cfg_din[SIZE_W +: TAG_W];
    assign cfg_size   = cfg_din[SIZE_W-1:0];
    assign cfg_size_w = CNT_W'(cfg_size);

    assign eligible   = active_q & src_valid & ~out_full;
    assign cur_onehot = FLUX'(1) << cur_q;

    // The current row moves one pixel whenever its source has data and its FIFO has room.
    assign xfer    = (state_q == STREAM) && src_valid[cur_q] && !out_full[cur_q];
    assign row_end = xfer && (row_cnt_q == SIZE_W'(1));
    assign last_px = row_end && (remaining_q[cur_q] == CNT_W'(1));

    // A flow retiring this cycle is still active, so the active check also covers that case.
    assign cfg_ok = cfg_write && (cfg_size != '0) && !active_q[cfg_flow]
                    && !(last_px && (cur_q == cfg_flow));

    // Zero-latency datapath: everything is gated by xfer so idle cycles drive zeros.
    assign out_write = xfer;
    assign out_din   = xfer ? {cur_q, src_din[cur_q*DATA_W +: DATA_W]} : '0;
    assign src_ready = xfer ? cur_onehot : '0;
    assign flow_done = last_px ? cur_onehot : '0;
    assign cfg_err   = cfg_err_q;
    assign busy      = |active_q;

    // Round-robin pick: scan from rr_ptr+1 circularly, rr_ptr itself last.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 1; i <= FLUX; i++) begin
            if (!grant_found && eligible[(int'(rr_ptr_q) + i) % FLUX]) begin
                grant_found = 1'b1;
                grant_idx   = TAG_W'((int'(rr_ptr_q) + i) % FLUX);
            end
        end
    end

    // Next-state logic for the grant/stream sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (active_q != '0) state_d = SELECT;
            SELECT: begin
                if (active_q == '0)   state_d = IDLE;
                else if (grant_found) state_d = STREAM;
            end
            STREAM:  if (row_end) state_d = SELECT;
            default: state_d = IDLE;
        endcase
    end

    // State, counters and per-flow configuration tables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            cur_q     <= '0;
            row_cnt_q <= '0;
            active_q  <= '0;
            cfg_err_q <= 1'b0;
            // NOTE: the per-flow tables are a handful of registers, so they reset with the rest.
            for (int f = 0; f < FLUX; f++) begin
                row_len_q[f]   <= '0;
                remaining_q[f] <= '0;
            end
        end else begin
            // NOTE: all state here uses nonblocking assignments so every read sees pre-edge values.
            state_q   <= state_d;
            cfg_err_q <= cfg_write && !cfg_ok;

            if (state_q == SELECT && grant_found) begin
                cur_q     <= grant_idx;
                row_cnt_q <= row_len_q[grant_idx];
            end

            if (xfer) begin
                row_cnt_q          <= row_cnt_q - SIZE_W'(1);
                remaining_q[cur_q] <= remaining_q[cur_q] - CNT_W'(1);
                if (row_end) rr_ptr_q        <= cur_q;
                if (last_px) active_q[cur_q] <= 1'b0;
            end

            // Accepted writes only target inactive flows, so they never collide with cur_q.
            if (cfg_ok) begin
                row_len_q[cfg_flow]   <= cfg_size;
                remaining_q[cfg_flow] <= cfg_size_w * cfg_size_w;
                active_q[cfg_flow]    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flow_row_scheduler.sv
// Testbench for flow_row_scheduler: a scoreboard queue of expected {tag, pel, last}
// is filled by each scenario from the configured block sizes and round-robin order,
// and a negedge monitor pops and compares every datapath write.
module tb_flow_row_scheduler;

    localparam int FLUX   = 4;
    localparam int DATA_W = 8;
    localparam int SIZE_W = 7;
    localparam int TAG_W  = 2;

    logic                    clk;
    logic                    rst;
    logic                    cfg_write;
    logic [TAG_W+SIZE_W-1:0] cfg_din;
    logic                    cfg_err;
    logic [FLUX*DATA_W-1:0]  src_din;
    logic [FLUX-1:0]         src_valid;
    logic [FLUX-1:0]         src_ready;
    logic [TAG_W+DATA_W-1:0] out_din;
    logic                    out_write;
    logic [FLUX-1:0]         out_full;
    logic [FLUX-1:0]         flow_done;
    logic                    busy;

    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        bit                last;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   sent    [FLUX];   // pixels consumed per flow (source position)
    int   pk      [FLUX];   // pixels pushed to the scoreboard per flow
    int   ext_cfg [FLUX];   // extended block side configured per flow

    exp_t                    m_e;
    logic [TAG_W+DATA_W-1:0] m_din;
    logic [FLUX-1:0]         m_rdy;
    logic [FLUX-1:0]         m_done;

    flow_row_scheduler #(.FLUX(FLUX), .DATA_W(DATA_W), .SIZE_W(SIZE_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_write (cfg_write),
        .cfg_din   (cfg_din),
        .cfg_err   (cfg_err),
        .src_din   (src_din),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .out_din   (out_din),
        .out_write (out_write),
        .out_full  (out_full),
        .flow_done (flow_done),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DATA_W-1:0] pix(input int f, input int k);
        return DATA_W'((k * 7 + f * 61 + 3) & 255);
    endfunction

    // Source model: each flow presents its next pixel, advanced just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int f = 0; f < FLUX; f++) src_din[f*DATA_W +: DATA_W] = pix(f, sent[f]);
        end
    end

    // Monitor: every cycle out of reset, compare outputs against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                checks++;
                if (out_write) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write got din=%h expected no write", out_din);
                    end else begin
                        m_e    = exp_q.pop_front();
                        m_din  = {m_e.tag, m_e.data};
                        m_rdy  = FLUX'(1) << m_e.tag;
                        m_done = m_e.last ? m_rdy : '0;
                        if (out_din !== m_din || src_ready !== m_rdy || flow_done !== m_done) begin
                            errors++;
                            $display("FAIL scoreboard got din=%h rdy=%b done=%b expected din=%h rdy=%b done=%b",
                                     out_din, src_ready, flow_done, m_din, m_rdy, m_done);
                        end
                    end
                end else if (out_din !== '0 || src_ready !== '0 || flow_done !== '0) begin
                    errors++;
                    $display("FAIL idle_outputs got din=%h rdy=%b done=%b expected all zero",
                             out_din, src_ready, flow_done);
                end
                for (int f = 0; f < FLUX; f++) if (src_ready[f]) sent[f]++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic clear_model();
        exp_q.delete();
        for (int f = 0; f < FLUX; f++) begin
            sent[f]    = 0;
            pk[f]      = 0;
            ext_cfg[f] = 0;
        end
    endtask

    task automatic push_row(input int f);
        exp_t e;
        for (int i = 0; i < ext_cfg[f]; i++) begin
            e.tag  = TAG_W'(f);
            e.data = pix(f, pk[f]);
            e.last = (pk[f] == ext_cfg[f] * ext_cfg[f] - 1);
            exp_q.push_back(e);
            pk[f]++;
        end
    endtask

    // Expected row order when every configured flow stays eligible: next unfinished flow after ptr.
    task automatic push_rr(input int start_ptr);
        int  ptr;
        int  nf;
        bit  found;
        ptr = start_ptr;
        forever begin
            found = 1'b0;
            nf    = 0;
            for (int i = 1; i <= FLUX; i++) begin
                if (!found && ext_cfg[(ptr + i) % FLUX] > 0 &&
                    pk[(ptr + i) % FLUX] < ext_cfg[(ptr + i) % FLUX] * ext_cfg[(ptr + i) % FLUX]) begin
                    found = 1'b1;
                    nf    = (ptr + i) % FLUX;
                end
            end
            if (!found) break;
            push_row(nf);
            ptr = nf;
        end
    endtask

    task automatic do_cfg(input int f, input int sz, input logic exp_err);
        @(posedge clk);
        #1;
        cfg_write = 1'b1;
        cfg_din   = {TAG_W'(f), SIZE_W'(sz)};
        @(posedge clk);
        #1;
        cfg_write = 1'b0;
        cfg_din   = '0;
        checks++;
        if (cfg_err !== exp_err) begin
            errors++;
            $display("FAIL cfg_err_pulse flow=%0d size=%0d got %b expected %b", f, sz, cfg_err, exp_err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_width flow=%0d got %b expected 0", f, cfg_err);
        end
    endtask

    task automatic wait_sent(input int f, input int n, input int budget);
        int c;
        c = 0;
        while (sent[f] < n && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        checks++;
        if (sent[f] < n) begin
            errors++;
            $display("FAIL wait_sent flow=%0d got %0d expected %0d", f, sent[f], n);
        end
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            #1;
            c++;
        end while ((busy || exp_q.size() != 0) && c < budget);
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got busy=%b pending=%0d expected busy=0 pending=0", busy, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cfg_write = 1'b0;
        cfg_din   = '0;
        src_valid = '0;
        out_full  = '0;
        src_din   = '0;
        clear_model();
        repeat (2) @(negedge clk);
        checks++;
        if (out_write !== 1'b0 || out_din !== '0 || src_ready !== '0) begin
            errors++;
            $display("FAIL reset_datapath got wr=%b din=%h rdy=%b expected 0", out_write, out_din, src_ready);
        end
        checks++;
        if (flow_done !== '0 || cfg_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_status got done=%b err=%b busy=%b expected 0", flow_done, cfg_err, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single_flow();
        int writes;
        int run;
        int idle;
        int c;
        clear_model();
        src_valid  = '1;
        out_full   = '0;
        ext_cfg[0] = 15;
        push_rr(0);
        do_cfg(0, 15, 1'b0);
        writes = 0;
        run    = 0;
        idle   = 0;
        c      = 0;
        while (writes < 225 && c < 2000) begin
            @(negedge clk);
            #1;
            c++;
            if (out_write) begin
                if (writes > 0 && idle > 0) begin
                    checks++;
                    if (idle != 1 || run != 15) begin
                        errors++;
                        $display("FAIL row_gap got idle=%0d run=%0d expected idle=1 run=15", idle, run);
                    end
                end
                if (idle > 0) run = 0;
                run++;
                writes++;
                idle = 0;
            end else begin
                idle++;
            end
        end
        checks++;
        if (writes != 225) begin
            errors++;
            $display("FAIL single_count got %0d expected 225", writes);
        end
        wait_idle(100);
    endtask

    task automatic test_four_flows();
        int exp_tot [FLUX];
        clear_model();
        src_valid = '1;
        out_full  = '0;
        ext_cfg[0] = 15;
        ext_cfg[1] = 23;
        ext_cfg[2] = 39;
        ext_cfg[3] = 71;
        exp_tot[0] = 225;
        exp_tot[1] = 529;
        exp_tot[2] = 1521;
        exp_tot[3] = 5041;
        push_row(0);
        push_rr(0);
        do_cfg(0, 15, 1'b0);
        wait_sent(0, 1, 20);
        do_cfg(1, 23, 1'b0);
        do_cfg(2, 39, 1'b0);
        do_cfg(3, 71, 1'b0);
        wait_idle(9000);
        for (int f = 0; f < FLUX; f++) begin
            checks++;
            if (sent[f] != exp_tot[f]) begin
                errors++;
                $display("FAIL flow_total flow=%0d got %0d expected %0d", f, sent[f], exp_tot[f]);
            end
        end
    endtask

    task automatic test_back_pressure();
        clear_model();
        src_valid  = '1;
        out_full   = '0;
        ext_cfg[1] = 6;
        ext_cfg[2] = 3;
        push_row(1);
        push_rr(1);
        do_cfg(1, 6, 1'b0);
        wait_sent(1, 3, 20);
        @(posedge clk);
        #1;
        out_full = 4'b0010;
        // Flow 2 becomes eligible during the stall but must not pre-empt the row.
        do_cfg(2, 3, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_write !== 1'b0 || src_ready !== '0) begin
                errors++;
                $display("FAIL stall got wr=%b rdy=%b expected wr=0 rdy=0", out_write, src_ready);
            end
        end
        @(posedge clk);
        #1;
        out_full = '0;
        wait_idle(300);
    endtask

    task automatic test_skip();
        clear_model();
        src_valid  = 4'b1011;
        out_full   = '0;
        ext_cfg[1] = 8;
        ext_cfg[2] = 2;
        ext_cfg[3] = 2;
        // Flow 2 is not valid at the first SELECT, so 1 hands over to 3.
        push_row(1);
        push_row(3);
        push_rr(3);
        do_cfg(1, 8, 1'b0);
        wait_sent(1, 1, 20);
        do_cfg(2, 2, 1'b0);
        do_cfg(3, 2, 1'b0);
        wait_sent(3, 1, 50);
        @(posedge clk);
        #1;
        src_valid = '1;
        wait_idle(300);
    endtask

    task automatic test_cfg_errors();
        int c;
        clear_model();
        src_valid  = '1;
        out_full   = '0;
        ext_cfg[1] = 4;
        push_rr(0);
        do_cfg(1, 4, 1'b0);
        do_cfg(1, 23, 1'b1);
        do_cfg(2, 0, 1'b1);
        wait_idle(200);

        ext_cfg[0] = 2;
        push_rr(0);
        do_cfg(0, 2, 1'b0);
        c = 0;
        while (flow_done[0] !== 1'b1 && c < 50) begin
            @(negedge clk);
            #1;
            c++;
        end
        checks++;
        if (flow_done[0] !== 1'b1) begin
            errors++;
            $display("FAIL last_pixel_seen got %b expected 1", flow_done[0]);
        end
        cfg_write = 1'b1;
        cfg_din   = {TAG_W'(0), SIZE_W'(5)};
        @(posedge clk);
        #1;
        cfg_write = 1'b0;
        cfg_din   = '0;
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL cfg_retire_clash got %b expected 1", cfg_err);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_clash got %b expected 0", busy);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_stays_idle got %b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_row();
        clear_model();
        src_valid  = '1;
        out_full   = '0;
        ext_cfg[3] = 6;
        push_rr(0);
        do_cfg(3, 6, 1'b0);
        wait_sent(3, 8, 100);
        @(posedge clk);
        #1;
        checks++;
        if (out_write !== 1'b1) begin
            errors++;
            $display("FAIL mid_row_active got %b expected 1", out_write);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_write !== 1'b0 || src_ready !== '0 || out_din !== '0) begin
            errors++;
            $display("FAIL async_reset_datapath got wr=%b rdy=%b din=%h expected 0", out_write, src_ready, out_din);
        end
        checks++;
        if (flow_done !== '0 || busy !== 1'b0 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_status got done=%b busy=%b err=%b expected 0", flow_done, busy, cfg_err);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        ext_cfg[3] = 3;
        push_rr(0);
        checks++;
        if (busy !== 1'b0 || out_write !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got busy=%b wr=%b expected 0", busy, out_write);
        end
        do_cfg(3, 3, 1'b0);
        wait_idle(100);
        checks++;
        if (sent[3] != 9) begin
            errors++;
            $display("FAIL restart_count got %0d expected 9", sent[3]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_flow();
        test_four_flows();
        test_back_pressure();
        test_skip();
        test_cfg_errors();
        test_reset_mid_row();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
